// File: rtl/comp_32_bs.sv
// ---------------------------------------------------------------------------
// comp_32_bs
//
// Registered magnitude comparator with run-time signed/unsigned selection.
// Every rising edge of clk samples op1 (A), op2 (B) and sign. The four
// relation flags for that sample appear after the same edge and hold until
// the next edge. Latency is one cycle and a new compare is taken every cycle.
//
// Handshake: none. There is no valid/ready pair. Every edge outside reset is
// a compare, and the flags always describe the operands from the previous
// edge.
//
// Ports
//   clk     in   system clock, rising edge active
//   resetn  in   synchronous reset, ACTIVE HIGH despite its name
//   sign    in   1 = two's-complement compare, 0 = unsigned compare
//   op1     in   WIDTH-bit operand A
//   op2     in   WIDTH-bit operand B
//   eq      out  registered A == B
//   neq     out  registered A != B
//   grt     out  registered A >  B under the sampled mode
//   lss     out  registered A <  B under the sampled mode
//
// All four flags are 0 only during reset and on the edge that reset clears
// them. Outside reset exactly one of eq/grt/lss is set, and neq = grt | lss.
// ---------------------------------------------------------------------------
module comp_32_bs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sign,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             eq,
  output logic             neq,
  output logic             grt,
  output logic             lss
);

  localparam int MSB = WIDTH - 1;

  // Flipping the MSB maps the two's-complement range onto the unsigned range
  // in the same order (-2^(W-1) -> 0, 2^(W-1)-1 -> all ones). After the flip
  // a plain unsigned compare gives the signed ordering, and no overflow is
  // possible. The flip is applied only when sign = 1.
  logic [WIDTH-1:0] key_a;
  logic [WIDTH-1:0] key_b;
  logic             eq_c;
  logic             gt_c;
  logic             lt_c;

  always_comb begin
    key_a      = op1;
    key_b      = op2;
    key_a[MSB] = op1[MSB] ^ sign;
    key_b[MSB] = op2[MSB] ^ sign;
  end

  // Equality uses the raw operands because the mode does not change it.
  // grt is derived from eq and lss so that exactly one flag is set by
  // construction.
  always_comb begin
    eq_c = (op1 == op2);
    lt_c = (key_a < key_b);
    gt_c = ~eq_c & ~lt_c;
  end

  // Reset overrides the compare on the same edge. Any result in flight is
  // dropped.
  always_ff @(posedge clk) begin
    if (resetn) begin
      eq  <= 1'b0;
      neq <= 1'b0;
      grt <= 1'b0;
      lss <= 1'b0;
    end else begin
      eq  <= eq_c;
      neq <= ~eq_c;
      grt <= gt_c;
      lss <= lt_c;
    end
  end

endmodule

// File: tb/tb_comp_32_bs.sv
// ---------------------------------------------------------------------------
// tb_comp_32_bs
//
// Directed and randomised bench for comp_32_bs.
// Inputs change on the falling edge. The DUT captures them on the next
// rising edge, and the outputs are read 1 ns after that edge.
// Flags are compared as the 4-bit vector {eq, neq, grt, lss}.
// ---------------------------------------------------------------------------
module tb_comp_32_bs;

  localparam int W = 32;

  // Flag encodings in {eq, neq, grt, lss} order.
  localparam logic [3:0] F_ZERO = 4'b0000;
  localparam logic [3:0] F_EQ   = 4'b1000;
  localparam logic [3:0] F_GT   = 4'b0110;
  localparam logic [3:0] F_LT   = 4'b0101;

  logic         clk;
  logic         resetn;
  logic         sign;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         eq;
  logic         neq;
  logic         grt;
  logic         lss;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  comp_32_bs #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sign   (sign),
    .op1    (op1),
    .op2    (op2),
    .eq     (eq),
    .neq    (neq),
    .grt    (grt),
    .lss    (lss)
  );

  // ---------------- driver tasks ----------------
  // Applies one input vector and returns after the edge that captures it,
  // at the point where the flags can be read.
  task automatic drive(input logic rst, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    resetn = rst;
    sign   = s;
    op1    = a;
    op2    = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model. Signed ordering comes from $signed, independent of the
  // MSB-flip used in the design.
  function automatic logic [3:0] model(input logic s,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic lt;
    if (a == b) return F_EQ;
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    return lt ? F_LT : F_GT;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'd5, 32'd3);
      checks++;
      if ({eq, neq, grt, lss} !== F_ZERO) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i,
                 {eq, neq, grt, lss}, F_ZERO);
      end
    end
    drive(1'b0, 1'b0, 32'd5, 32'd3);
    checks++;
    if ({eq, neq, grt, lss} !== F_GT) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b",
               {eq, neq, grt, lss}, F_GT);
    end
  endtask

  task automatic test_equality();
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, s[0], 32'hDEADBEEF, 32'hDEADBEEF);
      checks++;
      if ({eq, neq, grt, lss} !== F_EQ) begin
        errors++;
        $display("FAIL equality sign=%0d: got %b expected %b", s,
                 {eq, neq, grt, lss}, F_EQ);
      end
    end
  endtask

  task automatic test_sign_divergence();
    logic [W-1:0] a_t[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    logic [W-1:0] b_t[4] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic         s_t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]   e_t[4] = '{F_GT, F_LT, F_LT, F_GT};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, s_t[i], a_t[i], b_t[i]);
      checks++;
      if ({eq, neq, grt, lss} !== e_t[i]) begin
        errors++;
        $display("FAIL sign_divergence[%0d] a=%h b=%h s=%0d: got %b expected %b",
                 i, a_t[i], b_t[i], s_t[i], {eq, neq, grt, lss}, e_t[i]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] a_t[4] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
    logic [W-1:0] b_t[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    logic         s_t[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]   e_t[4] = '{F_LT, F_GT, F_GT, F_LT};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, s_t[i], a_t[i], b_t[i]);
      checks++;
      if ({eq, neq, grt, lss} !== e_t[i]) begin
        errors++;
        $display("FAIL extremes[%0d] a=%h b=%h s=%0d: got %b expected %b",
                 i, a_t[i], b_t[i], s_t[i], {eq, neq, grt, lss}, e_t[i]);
      end
    end
  endtask

  // Inputs change every cycle. Each result must match the vector captured on
  // the immediately preceding edge.
  task automatic test_back_to_back();
    logic [W-1:0] a_t[4] = '{32'd3, 32'd7, 32'hFFFFFFFE, 32'd0};
    logic [W-1:0] b_t[4] = '{32'd7, 32'd3, 32'hFFFFFFFF, 32'd0};
    logic         s_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]   e_t[4] = '{F_LT, F_GT, F_LT, F_EQ};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, s_t[i], a_t[i], b_t[i]);
      checks++;
      if ({eq, neq, grt, lss} !== e_t[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b expected %b",
                 i, {eq, neq, grt, lss}, e_t[i]);
      end
    end
  endtask

  task automatic test_random_with_reset();
    logic [W-1:0] edges[6] = '{32'h00000000, 32'h00000001, 32'h7FFFFFFF,
                               32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         rst;
    logic [3:0]   exp;
    logic [3:0]   got;
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = edges[$urandom_range(0, 5)]; b = edges[$urandom_range(0, 5)]; end
        1: begin a = $urandom; b = a; end
        2: begin a = $urandom; b = a ^ (32'h1 << $urandom_range(0, 31)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      s   = 1'($urandom_range(0, 1));
      rst = (i == 5000);
      exp_q.push_back(rst ? F_ZERO : model(s, a, b));
      drive(rst, s, a, b);
      got = {eq, neq, grt, lss};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h s=%0d rst=%0d: got %b expected %b",
                 i, a, b, s, rst, got, exp);
      end
      if (!rst) begin
        checks++;
        if (((eq + grt + lss) != 1) || (neq !== ~eq)) begin
          errors++;
          $display("FAIL exclusivity[%0d]: got eq=%b neq=%b grt=%b lss=%b expected one-hot with neq=~eq",
                   i, eq, neq, grt, lss);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    resetn = 1'b1;
    sign   = 1'b0;
    op1    = '0;
    op2    = '0;
    test_reset();
    test_equality();
    test_sign_divergence();
    test_extremes();
    test_back_to_back();
    test_random_with_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
